// File: rtl/uartp_mode_initiator.sv
`default_nettype none
// ============================================================================
// Module   : uartp_mode_initiator
// Brief    : Host-side initiator of the UART mode-change handshake (0xFF, 0xF<mode>,
//            echo check, then local mode switch). Optional: UARTP_MODE_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uartp_mode_initiator #(
  parameter int         CLK_FREQ    = 50000000,
  parameter logic [3:0] INIT_MODE   = 4'd1,
  parameter int         TIMEOUT_CYC = 5000000,
  parameter int         MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  input  logic [3:0] i_cmd_mode,
  output logic       o_cmd_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [3:0] o_mode,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int c_CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_TO_MAX  = c_CNT_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_FF = 3'd1,
    S_WAIT_FF = 3'd2,
    S_SEND_FN = 3'd3,
    S_WAIT_FN = 3'd4,
    S_SWITCH  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_alive;
  logic [3:0]           r_new_mode;
  logic [3:0]           r_mode;
  logic                 r_done;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_waiting;
  logic                 w_sending;
  logic                 w_timeout;
  logic                 w_fail;
  logic [1:0]           w_fail_code;
  logic [7:0]           w_expect;
  logic                 w_can_retry;

  if (CLK_FREQ <= 0) begin : g_clk_chk
    $error("CLK_FREQ must be positive");
  end

  // r_alive keeps cmd_ready low while reset is held and releases it one cycle later
  assign o_cmd_ready = r_alive && (r_state == S_IDLE);
  assign w_accept    = o_cmd_ready && i_cmd_valid;
  assign w_illegal   = (i_cmd_mode == 4'hF);
  assign w_waiting   = (r_state == S_WAIT_FF) || (r_state == S_WAIT_FN);
  assign w_sending   = (r_state == S_SEND_FF) || (r_state == S_SEND_FN);
  assign w_timeout   = (r_cnt >= c_TO_LAST);

  assign o_mode      = r_mode;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

`ifdef UARTP_MODE_RETRY_EN
  localparam int c_RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [c_RTY_W-1:0] r_retry;

  assign w_can_retry = (r_retry < c_RTY_W'((MAX_RETRY < 0) ? 0 : MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (w_accept) begin
      r_retry <= '0;
    end else if (w_fail && w_can_retry) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign w_can_retry = 1'b0;

  if (MAX_RETRY < 0) begin : g_retry_chk
    $error("MAX_RETRY must not be negative");
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    w_fail      = 1'b0;
    w_fail_code = 2'd0;
    w_expect    = (r_state == S_WAIT_FF) ? 8'hFF : {4'hF, r_new_mode};
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_illegal) begin
          w_next = S_SEND_FF;
        end
      end
      S_SEND_FF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hFF;
        if (i_tx_ready) begin
          w_next = S_WAIT_FF;
        end
      end
      S_SEND_FN: begin
        o_tx_valid = 1'b1;
        o_tx_data  = {4'hF, r_new_mode};
        if (i_tx_ready) begin
          w_next = S_WAIT_FN;
        end
      end
      S_WAIT_FF, S_WAIT_FN: begin
        if (i_rx_valid) begin
          if (i_rx_data == w_expect) begin
            w_next = (r_state == S_WAIT_FF) ? S_SEND_FN : S_SWITCH;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = 2'd3;
          end
        end else if (w_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = 2'd2;
        end
        if (w_fail) begin
          w_next = w_can_retry ? S_SEND_FF : S_IDLE;
        end
      end
      S_SWITCH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive    <= 1'b0;
      r_new_mode <= INIT_MODE;
      r_mode     <= INIT_MODE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_cnt      <= '0;
    end else begin
      r_alive <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      // mode 0xF is refused up front: 0xFF would re-arm the responder mid-handshake
      if (w_accept) begin
        r_new_mode <= i_cmd_mode;
        r_err      <= w_illegal;
        r_err_code <= w_illegal ? 2'd1 : 2'd0;
      end
      if (w_sending) begin
        r_cnt <= '0;
      end else if (w_waiting && (r_cnt != c_TO_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fail && !w_can_retry) begin
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
      end
      if (r_state == S_SWITCH) begin
        r_mode <= r_new_mode;
        r_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uartp_mode_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uartp_mode_initiator
// Brief    : Directed, table-driven bench for uartp_mode_initiator with an
//            echoing responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uartp_mode_initiator;

  localparam int TO = 100;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_mode = 4'd0;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] mode;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  int n_chk = 0;
  int n_err = 0;

  // responder bookkeeping (written only by the responder process)
  int         echoes_given = 0;
  int         ff_cnt = 0;
  int         inj_seen = 0;
  logic [7:0] last_byte = 8'h00;
  // responder controls (written only by the main process)
  bit         echo_en = 1'b1;
  int         echo_stop_at = 1 << 30;
  int         bad_until = 0;
  int         inj_cnt = 0;
  logic [7:0] inj_byte = 8'h00;

  uartp_mode_initiator #(
    .CLK_FREQ   (50000000),
    .INIT_MODE  (4'd1),
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd_valid(cmd_valid),
    .i_cmd_mode (cmd_mode),
    .o_cmd_ready(cmd_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_mode     (mode),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  always #5 clk = ~clk;

  // echoing responder: one-cycle echo strobe right after each accepted byte
  initial begin : responder
    logic       xf;
    logic [7:0] xb;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      xf = tx_valid && tx_ready;
      xb = tx_data;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      if (xf) begin
        if (xb == 8'hFF) ff_cnt++;
        last_byte = xb;
      end
      if (inj_seen != inj_cnt) begin
        inj_seen++;
        rx_valid = 1'b1;
        rx_data  = inj_byte;
      end else if (xf && echo_en && (echoes_given < echo_stop_at)) begin
        rx_valid = 1'b1;
        rx_data  = (echoes_given < bad_until) ? 8'hFE : xb;
        echoes_given++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic [3:0] m);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input logic [3:0] old_mode, output bit got_done,
                          output bit got_err, output int lat);
    int busy_bad;
    busy_bad = 0;
    lat = 0;
    @(negedge clk);
    while (!(done || err) && lat < 1000) begin
      if (mode !== old_mode || cmd_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got_done = done;
    got_err  = err;
    chk("busy_mode_and_ready_stable", busy_bad, 0);
    chk("end_within_bound", (lat < 1000), 1);
  endtask

  typedef struct {
    logic [3:0] cmd;
    bit         echo;
    int         bad;
    bit         exp_done;
    logic [1:0] exp_code;
    logic [3:0] exp_mode;
    int         exp_ff;
    int         exp_lat;
  } vec_t;

  vec_t vt[7];

  initial begin : main
    bit         d;
    bit         e;
    int         lat;
    int         base_ff;
    int         bad_cnt;
    int         w;
    logic [3:0] old;

    vt[0] = '{4'h3, 1'b1, 0, 1'b1, 2'd0, 4'h3, 1, 5};
    vt[1] = '{4'hF, 1'b1, 0, 1'b0, 2'd1, 4'h3, 0, 0};
    vt[2] = '{4'h3, 1'b1, 0, 1'b1, 2'd0, 4'h3, 1, 5};
    vt[3] = '{4'h0, 1'b1, 0, 1'b1, 2'd0, 4'h0, 1, 5};
`ifdef UARTP_MODE_RETRY_EN
    vt[4] = '{4'h7, 1'b1, 1, 1'b1, 2'd0, 4'h7, 2, 7};
    vt[5] = '{4'hA, 1'b0, 0, 1'b0, 2'd2, 4'h7, MR + 1, (MR + 1) * (TO + 1)};
`else
    vt[4] = '{4'h7, 1'b1, 1, 1'b0, 2'd3, 4'h0, 1, 2};
    vt[5] = '{4'hA, 1'b0, 0, 1'b0, 2'd2, 4'h0, 1, TO + 1};
`endif
    vt[6] = '{4'hC, 1'b1, 0, 1'b1, 2'd0, 4'hC, 1, 5};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_mode", mode, 4'd1);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_err_code", err_code, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // stray rx byte while idle must be ignored
    inj_byte = 8'hFF;
    inj_cnt++;
    bad_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (err || done || !cmd_ready || tx_valid || mode != 4'd1) bad_cnt++;
    end
    chk("idle_rx_ignored", bad_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      old       = mode;
      base_ff   = ff_cnt;
      echo_en   = vt[i].echo;
      bad_until = echoes_given + vt[i].bad;
      issue_cmd(vt[i].cmd);
      wait_end(old, d, e, lat);
      chk($sformatf("v%0d_done", i), d, vt[i].exp_done);
      chk($sformatf("v%0d_err", i), e, !vt[i].exp_done);
      chk($sformatf("v%0d_err_code", i), err_code, vt[i].exp_code);
      chk($sformatf("v%0d_mode", i), mode, vt[i].exp_mode);
      chk($sformatf("v%0d_ff_sends", i), ff_cnt - base_ff, vt[i].exp_ff);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      if (vt[i].exp_done) chk($sformatf("v%0d_last_byte", i), last_byte, {4'hF, vt[i].cmd});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_1cyc", i), {done, err}, 2'b00);
      chk($sformatf("v%0d_ready_again", i), cmd_ready, 1);
      chk($sformatf("v%0d_code_held", i), err_code, vt[i].exp_code);
      echo_en = 1'b1;
    end

    // tx_ready stalled 50 cycles in SEND_FN
    old = mode;
    issue_cmd(4'h9);
    @(negedge clk);
    chk("stall_ff_out", {tx_valid, tx_data}, {1'b1, 8'hFF});
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    @(negedge clk);
    bad_cnt = 0;
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hF9) bad_cnt++;
    end
    chk("stall_tx_stable", bad_cnt, 0);
    chk("stall_mode_old", mode, old);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", {tx_valid, tx_data}, {1'b1, 8'hF9});
    @(posedge clk);
    @(negedge clk);
    chk("stall_valid_drops", tx_valid, 0);
    wait_end(old, d, e, lat);
    chk("stall_done", {d, e}, 2'b10);
    chk("stall_mode_new", mode, 4'h9);

    // asynchronous reset while waiting for the second echo
    echo_stop_at = echoes_given + 1;
    issue_cmd(4'h6);
    w = 0;
    @(negedge clk);
    while (!(tx_valid && tx_data == 8'hF6) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_rst_fn_seen", (w < 50), 1);
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("mid_rst_pre_mode", mode, 4'h9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mode", mode, 4'd1);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_done_err", {done, err}, 2'b00);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    echo_stop_at = 1 << 30;
    issue_cmd(4'h2);
    wait_end(4'd1, d, e, lat);
    chk("post_rst_done", {d, e}, 2'b10);
    chk("post_rst_mode", mode, 4'h2);
    chk("post_rst_latency", lat, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
